mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Parametrised successor to the pipeline memory stage. It sits between EX/MEM and MEM/WB and does the following:
- generates store lane data and byte strobes;
- drives a valid/ready data-memory request and waits for a variable-latency response;
- aligns and sign/zero-extends load data;
- flags misaligned accesses;
- stalls upstream while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (64 enables LD/SD/LWU).
ADDR_W, 32, memory address width; the address is in_alu_out[ADDR_W-1:0].
STRB_W, XLEN/8, byte-strobe width; derived, never overridden.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  EX/MEM entry is valid
in_alu_out  in  XLEN  ALU result / effective address
in_rd_addr  in  5  destination register
in_reg_write  in  1  register write enable
in_wb_mux  in  2  writeback select
in_funct3  in  3  load/store width and sign encoding
in_mem_read  in  1  op is a load
in_mem_write  in  1  op is a store
in_rs2  in  XLEN  store source data
in_pc  in  XLEN  instruction PC
stall  out  1  upstream must hold inputs
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = store
mem_req_addr  out  ADDR_W  address, aligned down to STRB_W
mem_req_wdata  out  XLEN  lane-shifted store data
mem_req_strb  out  STRB_W  byte enables
mem_rsp_valid  in  1  load response valid
mem_rsp_rdata  in  XLEN  raw load word
wb_valid, wb_reg_write  out  1 each  MEM/WB valid and write enable
wb_alu_out, wb_load_data, wb_pc  out  XLEN each
wb_rd_addr  out  5
wb_wb_mux  out  2
wb_misaligned  out  1  misaligned-access exception

Behaviour:
- Clocking and reset: single clock `clk`. Reset is synchronous and active-low on `rst_n`. Under reset every wb_* output and mem_req_valid/we/addr/wdata/strb are 0, and the FSM is in IDLE.
- Byte offset: off = in_alu_out[log2(STRB_W)-1:0].
- Access size from funct3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double.
  - Size 3 is legal only when XLEN = 64. With XLEN = 32 it is treated as word.
- Misaligned access: half with off[0] set, word with off[1:0] nonzero, or double with off[2:0] nonzero.
  - No memory request is issued.
  - Single-cycle pass-through with wb_misaligned = 1 and wb_reg_write forced to 0.
- Store lanes:
  - wdata = rs2 shifted left by off*8.
  - strb = ((1 << bytes) - 1) << off.
  - Word on XLEN = 32 gives strb = all ones.
- Load extract:
  - raw = rdata >> (off*8).
  - funct3[2] = 0: sign-extend at the access width.
  - funct3[2] = 1: zero-extend.
  - Full-width loads (LW on 32, LD on 64) are passed through unchanged.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: a non-memory op, misaligned op, or in_valid = 0 is registered into MEM/WB at the next edge (1-cycle latency, stall = 0). A valid, aligned mem op drives stall = 1, latches addr/we/wdata/strb/off/funct3, and moves to REQ.
  - REQ: mem_req_valid = 1, with request fields stable until accepted. On mem_req_ready, a store goes to DONE and a load goes to WAIT.
  - WAIT: mem_req_valid = 0. On mem_rsp_valid, capture the extracted data and go to DONE.
  - DONE: stall = 0. MEM/WB loads the held op (wb_load_data = captured data, or 0 for a store) and the FSM returns to IDLE.
- Stall and latency:
  - stall = 1 in IDLE-with-mem-op, REQ and WAIT; 0 otherwise.
  - While stall = 1, MEM/WB receives a bubble: wb_valid = 0, wb_reg_write = 0.
  - Minimum latency with ready = 1 is 3 cycles for a store and 4 cycles for a load with a 1-cycle response.
- Boundary conditions:
  - mem_rsp_valid outside WAIT is ignored.
  - Ready and response in the same cycle as entering WAIT cannot occur; the response is sampled only in WAIT.
  - Reset mid-transaction aborts to IDLE and drops mem_req_valid; any late response is ignored.
  - in_mem_read and in_mem_write both set is treated as a store.

Decomposition:
- Shared package:
  - funct3 width codes (BYTE/HALF/WORD/DOUBLE);
  - sign bit position;
  - wb_mux codes;
  - FSM state enum.
- Sub-module mem_align: combinational store lane/strobe generation, load extract/extend, and misalignment detect. Parametrised by XLEN and instantiated once.

Test Plan:
- XLEN=32, SB: rs2=0x000000A5, addr=0x1003, ready=1. Expect wdata=0xA5000000 and strb=4'b1000; wb_valid rises exactly 3 cycles after the op is presented.
- XLEN=32, LH: funct3=001, addr=0x2002, rdata=0x8001_1234, response 2 cycles after accept. Expect wb_load_data=0xFFFF8001 and stall held through WAIT.
- XLEN=32, LHU: same as the LH case. Expect wb_load_data=0x00008001. Separately, LW at addr=0x2001 issues no request and gives wb_misaligned=1, wb_reg_write=0 in 1 cycle.
- XLEN=64, LWU: addr=0x...04, rdata=0xDEADBEEF_00000000. Expect 0x00000000DEADBEEF. SD at addr 0x...08 gives strb=8'hFF.
- Backpressure: mem_req_ready low for 5 cycles. Expect mem_req_valid and addr/wdata/strb stable throughout and stall=1. Then ALU op back-to-back after DONE writes WB on the next cycle.
- rst_n low during WAIT. Expect IDLE next edge, all wb_* = 0, mem_req_valid = 0. A subsequent stray mem_rsp_valid causes no writeback.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory access stage: access-size codes, writeback
// select codes, FSM states and the effective-size helper.
package mem_access_stage_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    // funct3 bit that selects zero-extension for loads
    localparam int SIGN_BIT = 2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    // A double access on a 32-bit datapath behaves as a word access.
    function automatic logic [1:0] eff_size(input logic [2:0] funct3, input int xlen);
        if (xlen == 32 && funct3[1:0] == SZ_DOUBLE) return SZ_WORD;
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store data/strobe placement, load extract with
// sign/zero extension, and misaligned-access detection.
module mem_align
    import mem_access_stage_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata,
    output logic [STRB_W-1:0] strb,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);

    logic [1:0]      size;
    logic [6:0]      nbits;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top_bit;
    logic            sign;

    // NOTE: every output of this block is assigned before any conditional
    // logic, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        size       = eff_size(funct3, XLEN);
        nbits      = 7'd8 << size;
        wdata      = rs2 << {off, 3'b000};
        strb       = ~({STRB_W{1'b1}} << nbits[6:3]) << off;
        raw        = rdata >> {off, 3'b000};
        // A shift by the full width yields zero, so full-width loads keep all bits.
        keep       = ~({XLEN{1'b1}} << nbits);
        top_bit    = keep ^ (keep >> 1);
        sign       = !funct3[SIGN_BIT] && |(raw & top_bit);
        load_data  = (raw & keep) | ({XLEN{sign}} & ~keep);
        misaligned = 1'b0;
        case (size)
            SZ_HALF:   misaligned = off[0];
            SZ_WORD:   misaligned = |off[1:0];
            SZ_DOUBLE: misaligned = |off;
            default:   misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage between EX/MEM and MEM/WB: issues a valid/ready data
// memory request, waits for a variable-latency response and stalls upstream.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 32,
    localparam int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_alu_out,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_mux,
    input  logic [2:0]        in_funct3,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_pc,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_strb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [XLEN-1:0]   wb_alu_out,
    output logic [XLEN-1:0]   wb_load_data,
    output logic [XLEN-1:0]   wb_pc,
    output logic [4:0]        wb_rd_addr,
    output logic [1:0]        wb_wb_mux,
    output logic              wb_misaligned
);

    localparam int OFF_W = $clog2(STRB_W);

    state_t            state, next_state;
    logic [OFF_W-1:0]  off_q, align_off;
    logic [2:0]        funct3_q, align_funct3;
    logic [XLEN-1:0]   align_wdata, align_load;
    logic [STRB_W-1:0] align_strb;
    logic              align_mis;
    logic              is_mem, misaligned, start_mem;
    logic [XLEN-1:0]   alu_q, pc_q, load_q;
    logic [4:0]        rd_q;
    logic              reg_write_q;
    logic [1:0]        wb_mux_q;

    assign is_mem     = in_valid && (in_mem_read || in_mem_write);
    assign misaligned = is_mem && align_mis;
    assign start_mem  = is_mem && !align_mis;

    // In IDLE the aligner sees the incoming op; afterwards the held one.
    assign align_off    = (state == IDLE) ? in_alu_out[OFF_W-1:0] : off_q;
    assign align_funct3 = (state == IDLE) ? in_funct3 : funct3_q;

    mem_align #(.XLEN(XLEN)) u_align (
        .off        (align_off),
        .funct3     (align_funct3),
        .rs2        (in_rs2),
        .rdata      (mem_rsp_rdata),
        .wdata      (align_wdata),
        .strb       (align_strb),
        .load_data  (align_load),
        .misaligned (align_mis)
    );

    // NOTE: reset is synchronous: rst_n is only looked at on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start_mem) begin
                    stall      = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) next_state = mem_req_we ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rsp_valid) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields and the held op are captured once and stay stable until DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_strb  <= '0;
            off_q         <= '0;
            funct3_q      <= '0;
            alu_q         <= '0;
            pc_q          <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            wb_mux_q      <= '0;
            load_q        <= '0;
        end else if (state == IDLE && start_mem) begin
            mem_req_we    <= in_mem_write;
            mem_req_addr  <= {in_alu_out[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_wdata <= align_wdata;
            mem_req_strb  <= align_strb;
            off_q         <= in_alu_out[OFF_W-1:0];
            funct3_q      <= in_funct3;
            alu_q         <= in_alu_out;
            pc_q          <= in_pc;
            rd_q          <= in_rd_addr;
            reg_write_q   <= in_reg_write;
            wb_mux_q      <= in_wb_mux;
            load_q        <= '0;
        end else if (state == WAIT && mem_rsp_valid) begin
            load_q <= align_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
            wb_alu_out    <= '0;
            wb_load_data  <= '0;
            wb_pc         <= '0;
            wb_rd_addr    <= '0;
            wb_wb_mux     <= '0;
        end else begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (!start_mem) begin
                        wb_valid      <= in_valid;
                        wb_reg_write  <= in_valid && in_reg_write && !misaligned;
                        wb_misaligned <= misaligned;
                        wb_alu_out    <= in_alu_out;
                        wb_load_data  <= '0;
                        wb_pc         <= in_pc;
                        wb_rd_addr    <= in_rd_addr;
                        wb_wb_mux     <= in_wb_mux;
                    end
                end
                DONE: begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= reg_write_q;
                    wb_alu_out   <= alu_q;
                    wb_load_data <= load_q;
                    wb_pc        <= pc_q;
                    wb_rd_addr   <= rd_q;
                    wb_wb_mux    <= wb_mux_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: one XLEN=32 and one XLEN=64 instance,
// a responding memory model and queues of expected requests and writebacks.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, use64;
    logic        in_valid, in_reg_write, in_mem_read, in_mem_write;
    logic [63:0] in_alu_out, in_rs2, in_pc;
    logic [4:0]  in_rd_addr;
    logic [1:0]  in_wb_mux;
    logic [2:0]  in_funct3;
    logic        mem_req_ready, mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        v32, v64;

    logic        s32_stall, s32_req_valid, s32_req_we, s32_wb_valid, s32_wb_reg_write, s32_wb_mis;
    logic [31:0] s32_req_addr, s32_req_wdata, s32_wb_alu, s32_wb_load, s32_wb_pc;
    logic [3:0]  s32_req_strb;
    logic [4:0]  s32_wb_rd;
    logic [1:0]  s32_wb_mux;

    logic        s64_stall, s64_req_valid, s64_req_we, s64_wb_valid, s64_wb_reg_write, s64_wb_mis;
    logic [31:0] s64_req_addr;
    logic [63:0] s64_req_wdata, s64_wb_alu, s64_wb_load, s64_wb_pc;
    logic [7:0]  s64_req_strb;
    logic [4:0]  s64_wb_rd;
    logic [1:0]  s64_wb_mux;

    logic        o_stall, o_req_valid, o_req_we, o_wb_valid, o_wb_reg_write, o_wb_mis;
    logic [31:0] o_req_addr;
    logic [63:0] o_req_wdata, o_wb_alu, o_wb_load;
    logic [7:0]  o_req_strb;
    logic [4:0]  o_wb_rd;

    assign v32 = in_valid && !use64;
    assign v64 = in_valid && use64;

    mem_access_stage #(.XLEN(32), .ADDR_W(32)) d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_alu_out(in_alu_out[31:0]),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_wb_mux(in_wb_mux),
        .in_funct3(in_funct3), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_rs2(in_rs2[31:0]), .in_pc(in_pc[31:0]), .stall(s32_stall),
        .mem_req_valid(s32_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(s32_req_we),
        .mem_req_addr(s32_req_addr), .mem_req_wdata(s32_req_wdata), .mem_req_strb(s32_req_strb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata[31:0]),
        .wb_valid(s32_wb_valid), .wb_reg_write(s32_wb_reg_write), .wb_alu_out(s32_wb_alu),
        .wb_load_data(s32_wb_load), .wb_pc(s32_wb_pc), .wb_rd_addr(s32_wb_rd),
        .wb_wb_mux(s32_wb_mux), .wb_misaligned(s32_wb_mis)
    );

    mem_access_stage #(.XLEN(64), .ADDR_W(32)) d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_alu_out(in_alu_out),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_wb_mux(in_wb_mux),
        .in_funct3(in_funct3), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_rs2(in_rs2), .in_pc(in_pc), .stall(s64_stall),
        .mem_req_valid(s64_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(s64_req_we),
        .mem_req_addr(s64_req_addr), .mem_req_wdata(s64_req_wdata), .mem_req_strb(s64_req_strb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .wb_valid(s64_wb_valid), .wb_reg_write(s64_wb_reg_write), .wb_alu_out(s64_wb_alu),
        .wb_load_data(s64_wb_load), .wb_pc(s64_wb_pc), .wb_rd_addr(s64_wb_rd),
        .wb_wb_mux(s64_wb_mux), .wb_misaligned(s64_wb_mis)
    );

    always_comb begin
        if (use64) begin
            o_stall = s64_stall;         o_req_valid = s64_req_valid;   o_req_we = s64_req_we;
            o_req_addr = s64_req_addr;   o_req_wdata = s64_req_wdata;   o_req_strb = s64_req_strb;
            o_wb_valid = s64_wb_valid;   o_wb_reg_write = s64_wb_reg_write;
            o_wb_alu = s64_wb_alu;       o_wb_load = s64_wb_load;
            o_wb_rd = s64_wb_rd;         o_wb_mis = s64_wb_mis;
        end else begin
            o_stall = s32_stall;         o_req_valid = s32_req_valid;   o_req_we = s32_req_we;
            o_req_addr = s32_req_addr;   o_req_wdata = {32'b0, s32_req_wdata};
            o_req_strb = {4'b0, s32_req_strb};
            o_wb_valid = s32_wb_valid;   o_wb_reg_write = s32_wb_reg_write;
            o_wb_alu = {32'b0, s32_wb_alu}; o_wb_load = {32'b0, s32_wb_load};
            o_wb_rd = s32_wb_rd;         o_wb_mis = s32_wb_mis;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } req_exp_t;

    typedef struct {
        logic [63:0] load;
        logic        reg_write;
        logic        mis;
        logic [4:0]  rd;
        logic [63:0] alu;
    } wb_exp_t;

    req_exp_t req_q[$];
    wb_exp_t  wb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel64, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw,
                         input logic [63:0] alu, input logic [63:0] rs2);
        use64 = sel64;      in_valid = 1'b1;  in_funct3 = f3;  in_rd_addr = rd;
        in_reg_write = rw;  in_mem_read = mr; in_mem_write = mw;
        in_alu_out = alu;   in_rs2 = rs2;     in_pc = alu + 64'h100;
        in_wb_mux = mr ? WB_MEM : WB_ALU;
    endtask

    // Drive an op and push what the DUT is expected to do with it.
    task automatic issue(input bit sel64, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw,
                         input logic [63:0] alu, input logic [63:0] rs2,
                         input bit e_req, input logic [31:0] e_addr, input logic [63:0] e_wdata,
                         input logic [7:0] e_strb, input logic [63:0] e_load, input logic e_mis);
        req_exp_t r;
        wb_exp_t  w;
        drive(sel64, f3, rd, rw, mr, mw, alu, rs2);
        if (e_req) begin
            r.we = mw; r.addr = e_addr; r.wdata = e_wdata; r.strb = e_strb;
            req_q.push_back(r);
        end
        w.load = e_load; w.reg_write = rw && !e_mis; w.mis = e_mis; w.rd = rd; w.alu = alu;
        wb_q.push_back(w);
        #1;
        check("stall_on_issue", o_stall, e_req);
    endtask

    // Memory model plus writeback scoreboard; returns once the op retires.
    task automatic run_op(input string tag, input int ready_delay, input int rsp_delay,
                          input logic [63:0] rdata, input int exp_lat);
        int       req_cycles = 0;
        int       rsp_wait = -1;
        bit       got_req = 1'b0;
        bit       done = 1'b0;
        req_exp_t r;
        wb_exp_t  w;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (o_wb_valid) begin
                done = 1'b1;
                in_valid = 1'b0;
                check({tag, "_latency"}, cyc, exp_lat);
                if (wb_q.size() == 0) begin
                    check({tag, "_unexpected_wb"}, o_wb_valid, 1'b0);
                end else begin
                    w = wb_q.pop_front();
                    check({tag, "_load_data"}, o_wb_load, w.load);
                    check({tag, "_reg_write"}, o_wb_reg_write, w.reg_write);
                    check({tag, "_misaligned"}, o_wb_mis, w.mis);
                    check({tag, "_rd"}, o_wb_rd, w.rd);
                    check({tag, "_alu_out"}, o_wb_alu, w.alu);
                end
            end else if (o_req_valid) begin
                if (!got_req) begin
                    if (req_q.size() == 0) begin
                        check({tag, "_unexpected_req"}, o_req_valid, 1'b0);
                        r = '{we: o_req_we, addr: o_req_addr, wdata: o_req_wdata, strb: o_req_strb};
                    end else begin
                        r = req_q.pop_front();
                    end
                    got_req = 1'b1;
                end
                check({tag, "_req_we"}, o_req_we, r.we);
                check({tag, "_req_addr"}, o_req_addr, r.addr);
                check({tag, "_req_wdata"}, o_req_wdata, r.wdata);
                check({tag, "_req_strb"}, o_req_strb, r.strb);
                check({tag, "_stall_req"}, o_stall, 1'b1);
                if (req_cycles >= ready_delay) begin
                    mem_req_ready = 1'b1;
                    if (!r.we) rsp_wait = rsp_delay;
                end
                req_cycles++;
            end else if (rsp_wait >= 0) begin
                check({tag, "_stall_wait"}, o_stall, 1'b1);
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = rdata;
                end
                rsp_wait--;
            end
        end
        if (!done) check({tag, "_wb_timeout"}, done, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;        use64 = 1'b0;        in_valid = 1'b0;
        in_alu_out = '0;     in_rs2 = '0;         in_pc = '0;
        in_rd_addr = '0;     in_reg_write = 1'b0; in_wb_mux = '0;
        in_funct3 = '0;      in_mem_read = 1'b0;  in_mem_write = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        repeat (2) @(negedge clk);

        check("rst_wb_valid", o_wb_valid, 1'b0);
        check("rst_wb_reg_write", o_wb_reg_write, 1'b0);
        check("rst_wb_load", o_wb_load, 64'h0);
        check("rst_req_valid", o_req_valid, 1'b0);
        check("rst_req_addr", o_req_addr, 32'h0);
        check("rst_req_strb", o_req_strb, 8'h0);
        check("rst64_wb_valid", s64_wb_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // SB to the top byte lane of a word
        issue(0, 3'b000, 5'd1, 1'b0, 1'b0, 1'b1, 64'h1003, 64'hA5,
              1, 32'h1000, 64'hA500_0000, 8'h08, 64'h0, 1'b0);
        run_op("sb", 0, 0, 64'h0, 3);

        // LH / LHU on the upper half, response two cycles after accept
        issue(0, 3'b001, 5'd2, 1'b1, 1'b1, 1'b0, 64'h2002, 64'h0,
              1, 32'h2000, 64'h0, 8'h0C, 64'hFFFF_8001, 1'b0);
        run_op("lh", 0, 1, 64'h8001_1234, 5);
        issue(0, 3'b101, 5'd3, 1'b1, 1'b1, 1'b0, 64'h2002, 64'h0,
              1, 32'h2000, 64'h0, 8'h0C, 64'h0000_8001, 1'b0);
        run_op("lhu", 0, 1, 64'h8001_1234, 5);

        // LB with one-cycle response: minimum load latency
        issue(0, 3'b000, 5'd4, 1'b1, 1'b1, 1'b0, 64'h5001, 64'h0,
              1, 32'h5000, 64'h0, 8'h02, 64'hFFFF_FFF0, 1'b0);
        run_op("lb", 0, 0, 64'h0000_F000, 4);

        // Misaligned LW: no request, single-cycle pass-through
        issue(0, 3'b010, 5'd5, 1'b1, 1'b1, 1'b0, 64'h2001, 64'h0,
              0, 32'h0, 64'h0, 8'h0, 64'h0, 1'b1);
        run_op("lw_mis", 0, 0, 64'h0, 1);

        // XLEN=64: LWU from the upper word, SD full strobe
        issue(1, 3'b110, 5'd6, 1'b1, 1'b1, 1'b0, 64'h3004, 64'h0,
              1, 32'h3000, 64'h0, 8'hF0, 64'h0000_0000_DEAD_BEEF, 1'b0);
        run_op("lwu64", 0, 0, 64'hDEAD_BEEF_0000_0000, 4);
        issue(1, 3'b011, 5'd7, 1'b0, 1'b0, 1'b1, 64'h3008, 64'h1122_3344_5566_7788,
              1, 32'h3008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0);
        run_op("sd64", 0, 0, 64'h0, 3);

        // Backpressure on a SW, then an ALU op straight after DONE
        issue(0, 3'b010, 5'd8, 1'b0, 1'b0, 1'b1, 64'h4004, 64'hCAFE_F00D,
              1, 32'h4004, 64'hCAFE_F00D, 8'h0F, 64'h0, 1'b0);
        run_op("sw_bp", 5, 0, 64'h0, 8);
        issue(0, 3'b000, 5'd9, 1'b1, 1'b0, 1'b0, 64'h1234_5678, 64'h0,
              0, 32'h0, 64'h0, 8'h0, 64'h0, 1'b0);
        run_op("alu", 0, 0, 64'h0, 1);

        // Reset while a load sits in WAIT; a late response must be dropped
        drive(0, 3'b010, 5'd10, 1'b1, 1'b1, 1'b0, 64'h6000, 64'h0);
        @(negedge clk);
        check("rstw_req_valid", o_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstw_in_wait", o_stall, 1'b1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rstw_wb_valid", o_wb_valid, 1'b0);
        check("rstw_wb_reg_write", o_wb_reg_write, 1'b0);
        check("rstw_wb_load", o_wb_load, 64'h0);
        check("rstw_wb_alu", o_wb_alu, 64'h0);
        check("rstw_req_valid_drop", o_req_valid, 1'b0);
        check("rstw_stall", o_stall, 1'b0);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h5555_AAAA;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_rsp_no_wb", o_wb_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
